// File: rtl/jt12_slot_ring_pkg.sv
//------------------------------------------------------------------------------
// Module  : jt12_slot_ring_pkg
// Brief   : Shared slot-width helper and request FSM state encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package jt12_slot_ring_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } req_state_t;

  function automatic int slot_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/jt12_slot_ring.sv
//------------------------------------------------------------------------------
// Module  : jt12_slot_ring
// Brief   : Circulating per-slot parameter ring with host write/read channels.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jt12_slot_ring
  import jt12_slot_ring_pkg::*;
#(
  parameter int   width  = 5,
  parameter int   stages = 24,
  parameter logic rstval = 1'b0,
  localparam int  SW     = slot_width(stages)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             wr_req,
  input  logic [SW-1:0]    wr_slot,
  input  logic [width-1:0] wr_data,
  output logic             wr_busy,
  output logic             wr_ack,
  output logic             wr_err,
  input  logic             rd_req,
  input  logic [SW-1:0]    rd_slot,
  output logic             rd_busy,
  output logic [width-1:0] rd_data,
  output logic             rd_valid,
  output logic [SW-1:0]    cur_slot,
  output logic             zero,
  output logic [width-1:0] dout
);

  localparam logic [SW-1:0] c_last   = SW'(stages - 1);
  localparam logic [SW:0]   c_stages = (SW + 1)'(stages);

  logic [width-1:0] r_ring [stages];
  logic [SW-1:0]    r_cnt;

  req_state_t       r_wr_st;
  logic [SW-1:0]    r_wr_slot;
  logic [width-1:0] r_wr_data;
  logic             r_wr_ack;
  logic             r_wr_err;

  req_state_t       r_rd_st;
  logic [SW-1:0]    r_rd_slot;
  logic [width-1:0] r_rd_data;
  logic             r_rd_valid;

  logic [width-1:0] w_head;
  logic [width-1:0] w_nxt;
  logic             w_wr_match;
  logic             w_wr_hit;
  logic             w_rd_hit;
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign w_head     = r_ring[0];
  assign w_wr_match = (r_wr_st == ST_PEND) && (r_wr_slot == r_cnt);
  assign w_nxt      = w_wr_match ? r_wr_data : w_head;
  assign w_wr_hit   = clk_en && w_wr_match;
  assign w_rd_hit   = clk_en && (r_rd_st == ST_PEND) && (r_rd_slot == r_cnt);
  assign w_wr_ok    = ({1'b0, wr_slot} < c_stages);
  assign w_rd_ok    = ({1'b0, rd_slot} < c_stages);

  // Head leaves at index 0, tail re-enters at the top: slot k is at the head when cnt==k.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < stages; i++) r_ring[i] <= {width{rstval}};
      r_cnt <= '0;
    end else if (clk_en) begin
      for (int i = 0; i < stages - 1; i++) r_ring[i] <= r_ring[i+1];
      r_ring[stages-1] <= w_nxt;
      r_cnt            <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_st   <= ST_IDLE;
      r_wr_slot <= '0;
      r_wr_data <= '0;
      r_wr_ack  <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
      case (r_wr_st)
        ST_IDLE: begin
          if (wr_req) begin
            if (w_wr_ok) begin
              r_wr_slot <= wr_slot;
              r_wr_data <= wr_data;
              r_wr_st   <= ST_PEND;
            end else begin
              r_wr_ack <= 1'b1;
              r_wr_err <= 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (w_wr_hit) begin
            r_wr_ack <= 1'b1;
            r_wr_st  <= ST_IDLE;
          end
        end
        default: r_wr_st <= ST_IDLE;
      endcase
    end
  end

  // Capture samples the head before the tail reload, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_st    <= ST_IDLE;
      r_rd_slot  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_rd_st)
        ST_IDLE: begin
          if (rd_req) begin
            if (w_rd_ok) begin
              r_rd_slot <= rd_slot;
              r_rd_st   <= ST_PEND;
            end else begin
              r_rd_data  <= '0;
              r_rd_valid <= 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (w_rd_hit) begin
            r_rd_data  <= w_head;
            r_rd_valid <= 1'b1;
            r_rd_st    <= ST_IDLE;
          end
        end
        default: r_rd_st <= ST_IDLE;
      endcase
    end
  end

  assign wr_busy  = (r_wr_st == ST_PEND);
  assign wr_ack   = r_wr_ack;
  assign wr_err   = r_wr_err;
  assign rd_busy  = (r_rd_st == ST_PEND);
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign cur_slot = r_cnt;
  assign zero     = (r_cnt == '0);
  assign dout     = w_head;

endmodule

`default_nettype wire

// File: tb/tb_jt12_slot_ring.sv
//------------------------------------------------------------------------------
// Module  : tb_jt12_slot_ring
// Brief   : Self-checking bench for jt12_slot_ring with slot-indexed reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jt12_slot_ring;

  localparam int c_stages = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic       wr_req = 1'b0;
  logic [4:0] wr_slot = '0;
  logic [4:0] wr_data = '0;
  logic       rd_req = 1'b0;
  logic [4:0] rd_slot = '0;
  logic       wr_busy, wr_ack, wr_err, rd_busy, rd_valid, zero;
  logic [4:0] rd_data, cur_slot, dout;

  jt12_slot_ring #(.width(5), .stages(c_stages), .rstval(1'b0)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .wr_req(wr_req), .wr_slot(wr_slot), .wr_data(wr_data),
    .wr_busy(wr_busy), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_req(rd_req), .rd_slot(rd_slot), .rd_busy(rd_busy),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .cur_slot(cur_slot), .zero(zero), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       err;
    logic [4:0] data;
  } sb_t;

  typedef struct {
    bit         is_wr;
    logic [4:0] slot;
    logic [4:0] data;
    logic       exp_err;
    logic [4:0] exp_rd;
  } vec_t;

  sb_t        wq[$];
  sb_t        rq[$];
  int         checks = 0;
  int         errors = 0;
  int         tnow = 0;
  int         m_cnt = 0;
  logic [4:0] m_ring [c_stages];
  logic [4:0] m_rdata = '0;
  bit         m_wp = 0, m_rp = 0;
  int         m_ws = 0, m_rs = 0;
  logic [4:0] m_wd = '0;
  bit         seen_wr = 0, seen_rd = 0;
  logic       last_err = 1'b0;
  logic [4:0] last_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0d)", nm, act, exp, tnow);
    end
  endtask

  // Advance one clock: update the model for the coming edge, then compare at the negedge.
  task automatic tick();
    logic [4:0] old_head;
    sb_t        e;
    if (rst) begin
      m_cnt = 0; m_wp = 0; m_rp = 0; m_rdata = '0;
      for (int i = 0; i < c_stages; i++) m_ring[i] = '0;
      wq.delete(); rq.delete();
    end else begin
      old_head = m_ring[m_cnt];
      if (m_wp) begin
        if (clk_en && m_cnt == m_ws) begin
          m_ring[m_ws] = m_wd; m_wp = 0;
          e = '{due: tnow + 1, err: 1'b0, data: '0}; wq.push_back(e);
        end
      end else if (wr_req) begin
        if (int'(wr_slot) < c_stages) begin
          m_wp = 1; m_ws = int'(wr_slot); m_wd = wr_data;
        end else begin
          e = '{due: tnow + 1, err: 1'b1, data: '0}; wq.push_back(e);
        end
      end
      if (m_rp) begin
        if (clk_en && m_cnt == m_rs) begin
          m_rp = 0; m_rdata = old_head;
          e = '{due: tnow + 1, err: 1'b0, data: old_head}; rq.push_back(e);
        end
      end else if (rd_req) begin
        if (int'(rd_slot) < c_stages) begin
          m_rp = 1; m_rs = int'(rd_slot);
        end else begin
          m_rdata = '0;
          e = '{due: tnow + 1, err: 1'b0, data: '0}; rq.push_back(e);
        end
      end
      if (clk_en) m_cnt = (m_cnt == c_stages - 1) ? 0 : m_cnt + 1;
    end
    @(negedge clk);
    tnow++;
    chk("cur_slot", 32'(cur_slot), 32'(m_cnt));
    chk("zero", 32'(zero), 32'(m_cnt == 0));
    chk("dout", 32'(dout), 32'(m_ring[m_cnt]));
    chk("wr_busy", 32'(wr_busy), 32'(m_wp));
    chk("rd_busy", 32'(rd_busy), 32'(m_rp));
    chk("rd_data_hold", 32'(rd_data), 32'(m_rdata));
    if (wr_ack === 1'b1) begin
      seen_wr = 1; last_err = wr_err;
      if (wq.size() == 0) chk("wr_ack_unexpected", 32'(wr_ack), 32'd0);
      else begin
        e = wq.pop_front();
        chk("wr_ack_time", 32'(tnow), 32'(e.due));
        chk("wr_err", 32'(wr_err), 32'(e.err));
      end
    end else if (wq.size() > 0 && wq[0].due <= tnow) begin
      e = wq.pop_front();
      chk("wr_ack_missing", 32'(wr_ack), 32'd1);
    end
    if (rd_valid === 1'b1) begin
      seen_rd = 1; last_rd = rd_data;
      if (rq.size() == 0) chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      else begin
        e = rq.pop_front();
        chk("rd_valid_time", 32'(tnow), 32'(e.due));
        chk("rd_data", 32'(rd_data), 32'(e.data));
      end
    end else if (rq.size() > 0 && rq[0].due <= tnow) begin
      e = rq.pop_front();
      chk("rd_valid_missing", 32'(rd_valid), 32'd1);
    end
  endtask

  task automatic issue(input bit w, input bit r, input logic [4:0] slot, input logic [4:0] data);
    seen_wr = 0; seen_rd = 0;
    wr_req = w; rd_req = r; wr_slot = slot; rd_slot = slot; wr_data = data;
    tick();
    wr_req = 0; rd_req = 0;
  endtask

  task automatic wait_done(input string nm, input bit w, input bit r);
    int n = 0;
    while (((w && !seen_wr) || (r && !seen_rd)) && n < 60) begin
      tick(); n++;
    end
    chk(nm, 32'((!w || seen_wr) && (!r || seen_rd)), 32'd1);
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (m_cnt != target && n < 30) begin
      tick(); n++;
    end
  endtask

  initial begin
    vec_t vt[9];
    int   zc, n, frozen, tgt;

    vt[0] = '{1, 5'd0,  5'h03, 1'b0, 5'h00};
    vt[1] = '{1, 5'd23, 5'h1F, 1'b0, 5'h00};
    vt[2] = '{0, 5'd0,  5'h00, 1'b0, 5'h03};
    vt[3] = '{0, 5'd23, 5'h00, 1'b0, 5'h1F};
    vt[4] = '{1, 5'd24, 5'h07, 1'b1, 5'h00};
    vt[5] = '{0, 5'd31, 5'h00, 1'b0, 5'h00};
    vt[6] = '{0, 5'd12, 5'h00, 1'b0, 5'h00};
    vt[7] = '{1, 5'd12, 5'h0A, 1'b0, 5'h00};
    vt[8] = '{0, 5'd12, 5'h00, 1'b0, 5'h0A};

    // Reset and two full revolutions of the rstval-filled ring
    rst = 1; tick(); rst = 0;
    chk("reset_slot", 32'(cur_slot), 32'd0);
    chk("reset_zero", 32'(zero), 32'd1);
    zc = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (zero === 1'b1) zc++;
    end
    chk("zero_count", 32'(zc), 32'd2);

    // Out-of-range write is rejected on the next clock
    issue(1, 0, 5'd30, 5'h15);
    chk("oor_ack", 32'(wr_ack), 32'd1);
    chk("oor_err", 32'(wr_err), 32'd1);
    chk("oor_busy", 32'(wr_busy), 32'd0);
    repeat (3) tick();

    // Write slot 5 accepted at cnt=10 completes 19 clk_en edges later
    wait_cnt(10);
    issue(1, 0, 5'd5, 5'h1A);
    n = 0;
    while (!seen_wr && n < 30) begin
      tick(); n++;
    end
    chk("wr_latency", 32'(n), 32'd19);
    wait_cnt(5);
    chk("slot5_new", 32'(dout), 32'h1A);

    // Same-edge read and write of one slot returns the old value
    issue(1, 0, 5'd3, 5'h04); wait_done("w3_done", 1, 0);
    issue(1, 1, 5'd3, 5'h11); wait_done("wr3_done", 1, 1);
    chk("same_edge_old", 32'(last_rd), 32'h04);
    issue(0, 1, 5'd3, 5'h00); wait_done("r3_done", 0, 1);
    chk("reread_new", 32'(last_rd), 32'h11);

    for (int i = 0; i < 9; i++) begin
      issue(vt[i].is_wr, !vt[i].is_wr, vt[i].slot, vt[i].data);
      wait_done("vec_done", vt[i].is_wr, !vt[i].is_wr);
      if (vt[i].is_wr) chk("vec_err", 32'(last_err), 32'(vt[i].exp_err));
      else             chk("vec_rd", 32'(last_rd), 32'(vt[i].exp_rd));
    end

    // Frozen ring with a write pending
    tgt = (m_cnt + 3) % c_stages;
    issue(1, 0, 5'(tgt), 5'h0E);
    clk_en = 0;
    frozen = m_cnt;
    repeat (100) tick();
    chk("frozen_slot", 32'(cur_slot), 32'(frozen));
    chk("frozen_busy", 32'(wr_busy), 32'd1);
    chk("frozen_noack", 32'(seen_wr), 32'd0);
    clk_en = 1;
    wait_done("resume_done", 1, 0);

    // Reset drops a pending write and refills the ring
    tgt = (m_cnt + 10) % c_stages;
    issue(1, 0, 5'(tgt), 5'h15);
    repeat (2) tick();
    seen_wr = 0;
    rst = 1; tick(); rst = 0;
    chk("rst_busy", 32'(wr_busy), 32'd0);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("rst_fill", 32'(dout), 32'd0);
    end
    chk("rst_noack", 32'(seen_wr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
